// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit ALU: handshakes one command, sequences the ALU load and latency, returns the result.
// Optional operand chaining (last result as operand 1) is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [2:0]       alu_in_sel,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] OP_MULT    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  state_t     state, next_state;
  logic       init_q;
  logic       err_pend;
  logic [2:0] op_q;
  logic [3:0] wait_cnt;
  logic       accept;
  logic       illegal_in;
  logic [WIDTH-1:0] num1_in;

  function automatic logic [6:0] op_onehot(input logic [2:0] op);
    logic [6:0] sel;
    sel = 7'b0;
    if (op != OP_ILLEGAL) sel = 7'b1000000 >> op;
    return sel;
  endfunction

`ifdef ALU_SEQ_CHAIN_EN
  logic chain_ok;
  assign illegal_in = (cmd_op == OP_ILLEGAL) || (cmd_chain && !chain_ok);
  assign num1_in    = cmd_chain ? res_data : cmd_a;
`else
  assign illegal_in = (cmd_op == OP_ILLEGAL);
  assign num1_in    = cmd_a;
`endif

  // An illegal command spends one IDLE cycle with err_pend set so its result appears one edge after acceptance.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    res_valid  = 1'b0;
    alu_in_sel = init_q ? 3'b001 : 3'b100;
    case (state)
      S_IDLE: begin
        if (err_pend) begin
          next_state = S_DONE;
        end else begin
          cmd_ready = !init_q;
          accept    = cmd_valid && !init_q;
          if (accept) next_state = illegal_in ? S_IDLE : S_LOAD;
        end
      end
      S_LOAD: begin
        alu_in_sel = 3'b010;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) next_state = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      init_q      <= 1'b1;
      err_pend    <= 1'b0;
      op_q        <= 3'd0;
      wait_cnt    <= 4'd0;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= 7'b0;
      res_data    <= '0;
      res_ovf     <= 1'b0;
      res_err     <= 1'b0;
    end else begin
      state  <= next_state;
      init_q <= 1'b0;
      if (accept) begin
        op_q     <= cmd_op;
        res_err  <= illegal_in;
        err_pend <= illegal_in;
        if (illegal_in) begin
          res_data <= '0;
          res_ovf  <= 1'b0;
        end else begin
          alu_num1    <= num1_in;
          alu_num2    <= cmd_b;
          alu_out_sel <= op_onehot(cmd_op);
        end
      end else if (state == S_IDLE && err_pend) begin
        err_pend <= 1'b0;
      end
      if (state == S_LOAD) wait_cnt <= 4'(ALU_LAT - 1);
      if (state == S_WAIT) begin
        if (wait_cnt == 4'd0) begin
          res_data <= alu_result;
          res_ovf  <= (op_q == OP_MULT) ? alu_ovf : 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
        end
      end
    end
  end

`ifdef ALU_SEQ_CHAIN_EN
  always_ff @(posedge clk) begin
    if (rst) chain_ok <= 1'b0;
    else if (state == S_DONE && res_ready) chain_ok <= !res_err;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural single-cycle-latency ALU model and result scoreboard.
// Chaining sequences run only when ALU_SEQ_CHAIN_EN is defined.
module tb_alu_cmd_sequencer;
  localparam int WIDTH   = 8;
  localparam int ALU_LAT = 1;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       ovf;
    logic       err;
    int         hold;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ovf;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic cmd_chain = 1'b0;
  logic [WIDTH-1:0] alu_num1, alu_num2;
  logic [2:0] alu_in_sel;
  logic [6:0] alu_out_sel;
  logic [WIDTH-1:0] alu_result;
  logic alu_ovf;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic res_ovf, res_err;

  int   checks = 0;
  int   errors = 0;
  int   load_count = 0;
  exp_t sb[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_in_sel(alu_in_sel), .alu_out_sel(alu_out_sel),
    .alu_result(alu_result), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .res_err(res_err)
  );

  // Behavioural ALU: operands registered on a load cycle, result decoded from the one-hot output selector.
  logic [7:0]  alu_r1 = '0, alu_r2 = '0;
  logic [15:0] prod;
  always @(posedge clk) begin
    if (alu_in_sel == 3'b001) begin
      alu_r1 <= '0;
      alu_r2 <= '0;
    end else if (alu_in_sel == 3'b010) begin
      alu_r1 <= alu_num1;
      alu_r2 <= alu_num2;
      load_count <= load_count + 1;
    end
  end

  always_comb begin
    prod       = 16'(alu_r1) * 16'(alu_r2);
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_out_sel)
      7'b1000000: alu_result = alu_r1 & alu_r2;
      7'b0100000: alu_result = alu_r1 | alu_r2;
      7'b0010000: alu_result = ~alu_r1;
      7'b0001000: alu_result = alu_r1 ^ alu_r2;
      7'b0000100: alu_result = alu_r1 + alu_r2;
      7'b0000010: alu_result = alu_r1 - alu_r2;
      7'b0000001: begin
        alu_result = prod[7:0];
        alu_ovf    = |prod[15:8];
      end
      default: alu_result = '0;
    endcase
  end

  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [8:0]  r;
    p = 16'(a) * 16'(b);
    r = 9'd0;
    case (op)
      3'd0: r = {1'b0, a & b};
      3'd1: r = {1'b0, a | b};
      3'd2: r = {1'b0, ~a};
      3'd3: r = {1'b0, a ^ b};
      3'd4: r = {1'b0, a + b};
      3'd5: r = {1'b0, a - b};
      3'd6: r = {|p[15:8], p[7:0]};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_value({tag, " cmd_ready"}, 32'(cmd_ready), 32'd0);
    check_value({tag, " res_valid"}, 32'(res_valid), 32'd0);
    check_value({tag, " res_data"}, 32'(res_data), 32'd0);
    check_value({tag, " res_ovf"}, 32'(res_ovf), 32'd0);
    check_value({tag, " res_err"}, 32'(res_err), 32'd0);
    check_value({tag, " alu_num1"}, 32'(alu_num1), 32'd0);
    check_value({tag, " alu_num2"}, 32'(alu_num2), 32'd0);
    check_value({tag, " alu_out_sel"}, 32'(alu_out_sel), 32'd0);
    check_value({tag, " alu_in_sel"}, 32'(alu_in_sel), 32'b001);
  endtask

  // Drives one command, waits for acceptance, queues its expected result and checks the cycle after acceptance.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic chain, input logic [7:0] exp_data, input logic exp_ovf,
                               input logic exp_err, input logic [7:0] exp_num1);
    int   n;
    exp_t e;
    logic [6:0] sel;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      check_value("cmd_ready timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e.data = exp_data;
    e.ovf  = exp_ovf;
    e.err  = exp_err;
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    check_value("cmd_ready after accept", 32'(cmd_ready), 32'd0);
    if (exp_err) begin
      check_value("no load on illegal", 32'(alu_in_sel == 3'b010), 32'd0);
    end else begin
      sel = 7'b1000000 >> op;
      check_value("load in_sel", 32'(alu_in_sel), 32'b010);
      check_value("load out_sel", 32'(alu_out_sel), 32'(sel));
      check_value("load num1", 32'(alu_num1), 32'(exp_num1));
      check_value("load num2", 32'(alu_num2), 32'(b));
    end
  endtask

  // Waits for the result, optionally stalls it, then completes the handshake and compares against the scoreboard.
  task automatic checkOutput(input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      check_value("scoreboard empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (!res_valid) begin
      check_value("res_valid timeout", 32'(res_valid), 32'd1);
      return;
    end
    check_value("result latency", 32'(n), e.err ? 32'd1 : 32'(ALU_LAT + 1));
    for (int i = 0; i < hold; i++) begin
      check_value("stall res_data", 32'(res_data), 32'(e.data));
      check_value("stall cmd_ready", 32'(cmd_ready), 32'd0);
      check_value("stall res_valid", 32'(res_valid), 32'd1);
      tick();
    end
    res_ready = 1'b1;
    check_value("res_data", 32'(res_data), 32'(e.data));
    check_value("res_ovf", 32'(res_ovf), 32'(e.ovf));
    check_value("res_err", 32'(res_err), 32'(e.err));
    tick();
    res_ready = 1'b0;
    check_value("idle cmd_ready", 32'(cmd_ready), 32'd1);
    check_value("idle res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    int loads_before;
    logic [8:0] r;
    logic [2:0] op;
    logic [7:0] a, b;

    vecs[0]  = '{3'd4, 8'h25, 8'h13, 8'h38, 1'b0, 1'b0, 0};
    vecs[1]  = '{3'd7, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 0};
    vecs[2]  = '{3'd5, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 5};
    vecs[3]  = '{3'd6, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 0};
    vecs[4]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0};
    vecs[5]  = '{3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0, 0};
    vecs[6]  = '{3'd2, 8'h5A, 8'h77, 8'hA5, 1'b0, 1'b0, 0};
    vecs[7]  = '{3'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 0};
    vecs[8]  = '{3'd6, 8'h03, 8'h05, 8'h0F, 1'b0, 1'b0, 0};
    vecs[9]  = '{3'd4, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 2};
    vecs[10] = '{3'd5, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 0};

    $display("[TB] start");
    rst = 1'b1;
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check_value("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
    check_value("post-reset in_sel", 32'(alu_in_sel), 32'b100);

    for (int i = 0; i < 11; i++) begin
      loads_before = load_count;
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].data, vecs[i].ovf, vecs[i].err, vecs[i].a);
      checkOutput(vecs[i].hold);
      if (vecs[i].err) check_value("illegal load count", 32'(load_count), 32'(loads_before));
    end

    for (int i = 0; i < 4; i++) begin
      op = 3'($urandom_range(0, 6));
      a  = 8'($urandom);
      b  = 8'($urandom);
      r  = ref_alu(op, a, b);
      applyStimulus(op, a, b, 1'b0, r[7:0], r[8], 1'b0, a);
      checkOutput(0);
    end

    $display("[TB] reset during WAIT");
    applyStimulus(3'd4, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 8'h11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check_reset_values("wait reset");
    tick();
    check_value("wait reset ready", 32'(cmd_ready), 32'd1);
    repeat (3) tick();
    check_value("wait reset no result", 32'(res_valid), 32'd0);

`ifdef ALU_SEQ_CHAIN_EN
    $display("[TB] chaining");
    applyStimulus(3'd4, 8'h01, 8'h01, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);
    checkOutput(0);
    applyStimulus(3'd4, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 8'h05);
    checkOutput(0);
    applyStimulus(3'd5, 8'hAA, 8'h02, 1'b1, 8'h06, 1'b0, 1'b0, 8'h08);
    checkOutput(0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
